mem_stage_ctrl: RTL

Memory-stage controller of the 5-stage pipeline. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register. It runs load/store requests against an external data memory through a req/ack handshake and holds the front of the pipeline frozen while a request is in flight. It forwards writeback control, ALU result and destination register to MEM/WB, and inserts a writeback bubble while frozen.

---
 rtl/mem_stage_ctrl_pkg.sv | 20 ++
 rtl/mem_stage_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl_pkg.sv
// Shared constants for the memory-stage controller: pipeline word/register
// widths, timeout defaults and the FSM state encoding.
package mem_stage_ctrl_pkg;

  // Pipeline-wide widths shared with the other stages.
  localparam int unsigned MAX_LENGTH = 32;
  localparam int unsigned REG_LENGTH = 4;

  // Default number of BUSY cycles to wait for an ack before giving up.
  localparam int unsigned TimeoutDefault = 255;
  // Width of the timeout counter; TimeoutDefault must fit.
  localparam int unsigned CntWidth = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller. Sits between EX/MEM and MEM/WB, runs loads and
// stores against an external data memory over a req/ack handshake and freezes
// the front of the pipeline while a request is outstanding.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   wb_en_in, mem_r_en_in,
//   mem_w_en_in, alu_result_in,
//   st_val_in, dest_in              EX/MEM controls and data
//   wb_en_out, mem_r_en_out,
//   alu_result_out, dest_out,
//   mem_read_val                    to MEM/WB (wb_en_out bubbled while frozen)
//   freeze                          stall PC, IF/ID, ID/EX, EX/MEM
//   mem_req, mem_we, mem_addr,
//   mem_wdata                       registered memory request
//   mem_rdata, mem_ack              memory response
//   mem_err                         sticky ack-timeout flag
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned BASE_ADDR  = 1024,
  parameter int unsigned TIMEOUT    = TimeoutDefault
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_en_in,
  input  logic                  mem_r_en_in,
  input  logic                  mem_w_en_in,
  input  logic [MAX_LENGTH-1:0] alu_result_in,
  input  logic [MAX_LENGTH-1:0] st_val_in,
  input  logic [REG_LENGTH-1:0] dest_in,
  output logic                  wb_en_out,
  output logic                  mem_r_en_out,
  output logic [MAX_LENGTH-1:0] alu_result_out,
  output logic [REG_LENGTH-1:0] dest_out,
  output logic [MAX_LENGTH-1:0] mem_read_val,
  output logic                  freeze,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [MAX_LENGTH-1:0] mem_wdata,
  input  logic [MAX_LENGTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  mem_err
);

  mem_state_e state_q, state_d;

  logic                  req_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [MAX_LENGTH-1:0] wdata_q;
  logic [MAX_LENGTH-1:0] read_val_q;
  logic [CntWidth-1:0]   cnt_q;
  logic                  err_q;

  logic                  access;
  logic                  ack_hit;
  logic                  timed_out;
  logic [MAX_LENGTH-1:0] byte_off;
  logic [ADDR_WIDTH-1:0] word_addr;

  assign access = mem_r_en_in | mem_w_en_in;

  // Byte offset from the memory base; low two bits dropped, out-of-range
  // addresses wrap by truncation.
  assign byte_off  = alu_result_in - MAX_LENGTH'(BASE_ADDR);
  assign word_addr = ADDR_WIDTH'(byte_off >> 2);

  // Counter is 0 in the first BUSY cycle, so TIMEOUT-1 marks the last one.
  // An ack in that same cycle still wins over the timeout.
  assign ack_hit   = (state_q == StBusy) & mem_ack;
  assign timed_out = (state_q == StBusy) & ~mem_ack & (cnt_q == CntWidth'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (access) state_d = StBusy;
      StBusy: if (ack_hit || timed_out) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    freeze    = ((state_q == StIdle) & access) | (state_q == StBusy);
    // Bubble keeps MEM/WB from writing back stale load data while frozen.
    wb_en_out = wb_en_in & ~freeze;
  end

  // Request, response and timeout registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      read_val_q <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (access) begin
            req_q   <= 1'b1;
            we_q    <= mem_w_en_in;
            addr_q  <= word_addr;
            wdata_q <= st_val_in;
            cnt_q   <= '0;
          end
        end
        StBusy: begin
          cnt_q <= cnt_q + CntWidth'(1);
          if (ack_hit) begin
            req_q <= 1'b0;
            if (!we_q) read_val_q <= mem_rdata;
          end else if (timed_out) begin
            req_q      <= 1'b0;
            err_q      <= 1'b1;
            read_val_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req        = req_q;
  assign mem_we         = we_q;
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign mem_read_val   = read_val_q;
  assign mem_err        = err_q;
  assign mem_r_en_out   = mem_r_en_in;
  assign alu_result_out = alu_result_in;
  assign dest_out       = dest_in;

endmodule
